// File: rtl/func_lut_pkg.sv
// Shared types and the quadratic evaluator used by the func_lut scheduler.
package func_lut_pkg;

    typedef enum logic {
        OP_FWD = 1'b0,
        OP_INV = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FWD,
        S_INV,
        S_RESP
    } state_e;

    // y = a*x^2 + b*x + c in 32 bits, wrapped to w_y bits and sign-extended back.
    function automatic logic signed [31:0] quad(
        input logic signed [31:0] x,
        input int                 a,
        input int                 b,
        input int                 c,
        input int unsigned        w_y
    );
        logic signed [31:0] full;
        int unsigned        sh;
        full = a * x * x + b * x + c;
        sh   = 32 - w_y;
        return (full <<< sh) >>> sh;
    endfunction

endpackage

// File: rtl/func_lut_rr_arb.sv
// Round-robin arbiter: first valid requester at or after rr_ptr_i wins.
module func_lut_rr_arb #(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned IW    = $clog2(N_REQ)
) (
    input  logic             en_i,
    input  logic [N_REQ-1:0] valid_i,
    input  logic [IW-1:0]    rr_ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IW-1:0]    gnt_idx_o,
    output logic             gnt_any_o
);

    logic [IW-1:0] idx;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_any_o = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = IW'((32'(rr_ptr_i) + i) % N_REQ);
            if (en_i && !gnt_any_o && valid_i[idx]) begin
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
                gnt_any_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/func_lut_sched.sv
// Shares one quadratic evaluator between N_REQ requesters for forward
// evaluation and inverse lookup by a one-candidate-per-cycle sweep.
module func_lut_sched
    import func_lut_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    parameter  int unsigned W_x   = 4,
    parameter  int unsigned W_y   = 8,
    parameter  int          A     = 1,
    parameter  int          B     = 10,
    parameter  int          C     = -10,
    localparam int unsigned IW    = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ-1:0]     req_op,
    input  logic [N_REQ*W_x-1:0] req_x,
    input  logic [N_REQ*W_y-1:0] req_y,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IW-1:0]        resp_id,
    output logic                 resp_op,
    output logic [W_y-1:0]       resp_y,
    output logic [W_x-1:0]       resp_x,
    output logic [W_y:0]         resp_err
);

    localparam int unsigned W_E = W_y + 1;

    state_e                 state_q, state_d;
    logic [IW-1:0]          rr_q, rr_d;
    logic signed [W_x-1:0]  x_q, x_d;
    logic signed [W_y-1:0]  y_q, y_d;
    logic [W_x-1:0]         ux_q, ux_d;
    logic                   resp_valid_q, resp_valid_d;
    logic                   resp_op_q, resp_op_d;
    logic [IW-1:0]          resp_id_q, resp_id_d;
    logic [W_y-1:0]         resp_y_q, resp_y_d;
    logic [W_x-1:0]         resp_x_q, resp_x_d;
    logic [W_E-1:0]         resp_err_q, resp_err_d;

    logic [N_REQ-1:0]       gnt;
    logic [IW-1:0]          gnt_idx;
    logic                   gnt_any;
    logic signed [W_x-1:0]  cand;
    logic signed [W_x-1:0]  op_x;
    logic signed [31:0]     q_val;
    logic signed [31:0]     diff;
    logic [31:0]            err;

    // Grants only in IDLE and never while reset is asserted.
    func_lut_rr_arb #(.N_REQ(N_REQ)) u_arb (
        .en_i      ((state_q == S_IDLE) && rst_n),
        .valid_i   (req_valid),
        .rr_ptr_i  (rr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_any_o (gnt_any)
    );

    // Single shared evaluator: latched operand in FWD, sweep candidate otherwise.
    always_comb begin
        cand  = signed'(ux_q);
        op_x  = (state_q == S_FWD) ? x_q : cand;
        q_val = quad(32'(op_x), A, B, C, W_y);
        diff  = 32'(y_q) - q_val;
        err   = (diff < 0) ? -diff : diff;
    end

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        x_d          = x_q;
        y_d          = y_q;
        ux_d         = ux_q;
        resp_valid_d = resp_valid_q;
        resp_op_d    = resp_op_q;
        resp_id_d    = resp_id_q;
        resp_y_d     = resp_y_q;
        resp_x_d     = resp_x_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_any) begin
                    resp_id_d = gnt_idx;
                    resp_op_d = req_op[gnt_idx];
                    x_d       = req_x[32'(gnt_idx)*W_x +: W_x];
                    y_d       = req_y[32'(gnt_idx)*W_y +: W_y];
                    rr_d      = IW'((32'(gnt_idx) + 1) % N_REQ);
                    ux_d      = '0;
                    resp_y_d  = '0;
                    resp_x_d  = '0;
                    if (req_op[gnt_idx] == OP_INV) begin
                        resp_err_d = W_E'(1) << W_y;
                        state_d    = S_INV;
                    end else begin
                        resp_err_d = '0;
                        state_d    = S_FWD;
                    end
                end
            end
            S_FWD: begin
                resp_y_d     = W_y'(q_val);
                resp_valid_d = 1'b1;
                state_d      = S_RESP;
            end
            S_INV: begin
                // Strict compare keeps the earliest candidate on ties.
                if (err < 32'(resp_err_q)) begin
                    resp_x_d   = cand;
                    resp_err_d = W_E'(err);
                end
                ux_d = ux_q + 1'b1;
                if (ux_q == '1) begin
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rr_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            ux_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_op_q    <= 1'b0;
            resp_id_q    <= '0;
            resp_y_q     <= '0;
            resp_x_q     <= '0;
            resp_err_q   <= '0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            x_q          <= x_d;
            y_q          <= y_d;
            ux_q         <= ux_d;
            resp_valid_q <= resp_valid_d;
            resp_op_q    <= resp_op_d;
            resp_id_q    <= resp_id_d;
            resp_y_q     <= resp_y_d;
            resp_x_q     <= resp_x_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = gnt;
    assign resp_valid = resp_valid_q;
    assign resp_op    = resp_op_q;
    assign resp_id    = resp_id_q;
    assign resp_y     = resp_y_q;
    assign resp_x     = resp_x_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_func_lut_sched.sv
// Scoreboard bench for func_lut_sched: stimulus pushes expected responses,
// a negedge monitor pops and compares each accepted response.
module tb_func_lut_sched;

    localparam int unsigned N  = 4;
    localparam int unsigned WX = 4;
    localparam int unsigned WY = 8;
    localparam int unsigned IW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_ready, req_op;
    logic [N*WX-1:0] req_x;
    logic [N*WY-1:0] req_y;
    logic            resp_valid, resp_ready, resp_op;
    logic [IW-1:0]   resp_id;
    logic [WY-1:0]   resp_y;
    logic [WX-1:0]   resp_x;
    logic [WY:0]     resp_err;

    always #5 clk = ~clk;

    func_lut_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_x      (req_x),
        .req_y      (req_y),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_op    (resp_op),
        .resp_y     (resp_y),
        .resp_x     (resp_x),
        .resp_err   (resp_err)
    );

    typedef struct {
        int id;
        int op;
        int y;
        int x;
        int err;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   hs_cyc = 0;
    int   lat    = 0;
    int   n_hs   = 0;
    bit   busy   = 1'b0;
    bit   prev_rv = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: latency, busy-grant and scoreboard comparison.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy    = 1'b0;
            prev_rv = 1'b0;
        end else begin
            if (busy) chk("ready_while_busy", int'(req_ready), 0);
            if (resp_valid && !prev_rv) lat = cyc - hs_cyc;
            prev_rv = resp_valid;
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", int'(resp_id), -1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_id", int'(resp_id), e.id);
                    chk("resp_op", int'(resp_op), e.op);
                    chk("resp_y", int'($signed(resp_y)), e.y);
                    chk("resp_x", int'($signed(resp_x)), e.x);
                    chk("resp_err", int'(resp_err), e.err);
                    if (e.lat != 0) chk("latency", lat, e.lat);
                end
                busy = 1'b0;
            end
            if (|(req_valid & req_ready)) begin
                hs_cyc = cyc;
                busy   = 1'b1;
                n_hs++;
            end
        end
    end

    task automatic issue(input int r, input bit op, input int xv, input int yv,
                         input bit push, input int ex_y, input int ex_x,
                         input int ex_err, input int ex_lat);
        bit got;
        exp_t e;
        req_op[r]           = op;
        req_x[r*WX +: WX]   = WX'(xv);
        req_y[r*WY +: WY]   = WY'(yv);
        req_valid[r]        = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (req_ready[r]) got = 1'b1;
        end
        chk("grant", int'(got), 1);
        if (got && push) begin
            e = '{r, int'(op), ex_y, ex_x, ex_err, ex_lat};
            sb.push_back(e);
        end
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
    endtask

    task automatic do_reset_and_regrant(input int ex_y, input int xv0);
        exp_t e;
        req_op[0] = 1'b0; req_x[0 +: WX] = WX'(xv0); req_valid[0] = 1'b1;
        req_op[3] = 1'b0; req_x[3*WX +: WX] = WX'(0); req_valid[3] = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_resp_valid", int'(resp_valid), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_resp_y", int'(resp_y), 0);
        chk("rst_resp_err", int'(resp_err), 0);
        @(posedge clk); #1;
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("grant_after_reset", int'(req_ready), 1);
        e = '{0, 0, ex_y, 0, 0, 2};
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid = '0;
    endtask

    initial begin
        int base;
        bit seen;
        rst_n      = 1'b0;
        resp_ready = 1'b1;
        req_valid  = '1;
        req_op     = '0;
        req_y      = '0;
        for (int r = 0; r < 4; r++) req_x[r*WX +: WX] = WX'(r);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_resp_valid", int'(resp_valid), 0);
        chk("reset_req_ready", int'(req_ready), 0);
        chk("reset_resp_id", int'(resp_id), 0);
        chk("reset_resp_y", int'(resp_y), 0);
        chk("reset_resp_x", int'(resp_x), 0);
        chk("reset_resp_err", int'(resp_err), 0);

        // Round robin: x=r gives -10, 1, 14, 29; order 0,1,2,3,0.
        sb.push_back('{0, 0, -10, 0, 0, 2});
        sb.push_back('{1, 0, 1, 0, 0, 2});
        sb.push_back('{2, 0, 14, 0, 0, 2});
        sb.push_back('{3, 0, 29, 0, 0, 2});
        sb.push_back('{0, 0, -10, 0, 0, 2});
        base = n_hs;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (n_hs >= base + 5) break;
        end
        req_valid = '0;
        chk("rr_grants", n_hs - base, 5);

        issue(2, 1'b0, 2, 0, 1'b1, 14, 0, 0, 2);
        issue(1, 1'b1, 0, 14, 1'b1, 0, 2, 0, 17);
        issue(3, 1'b1, 0, 0, 1'b1, 0, 1, 1, 17);
        issue(0, 1'b1, 0, -128, 1'b1, 0, -5, 93, 17);
        issue(2, 1'b1, 0, 127, 1'b1, 0, 7, 18, 17);
        issue(3, 1'b1, 0, -34, 1'b1, 0, -6, 0, 17);
        issue(1, 1'b0, -8, 0, 1'b1, -26, 0, 0, 2);

        // Hold response for 5 cycles, then reset in RESP (rr_ptr was 2).
        repeat (4) @(posedge clk); #1;
        resp_ready = 1'b0;
        issue(1, 1'b0, 3, 0, 1'b0, 0, 0, 0, 0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        chk("hold_resp_seen", int'(seen), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", int'(resp_valid), 1);
            chk("hold_id", int'(resp_id), 1);
            chk("hold_y", int'($signed(resp_y)), 29);
        end
        @(posedge clk); #1;
        do_reset_and_regrant(-26, -8);

        // Reset in the middle of an inverse sweep (rr_ptr would be 3).
        repeat (4) @(posedge clk); #1;
        issue(2, 1'b1, 0, 14, 1'b0, 0, 0, 0, 0);
        repeat (5) @(posedge clk); #1;
        do_reset_and_regrant(109, 7);

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
